// File: rtl/disp_fifo_defs.sv
// Shared definitions for the display command FIFO writer and reader sides:
// state encodings, flag polarities and default timing.
package disp_fifo_defs;

    typedef enum logic [2:0] {
        WR_IDLE    = 3'd0,
        WR_SETUP   = 3'd1,
        WR_PULSE   = 3'd2,
        WR_HOLD    = 3'd3,
        WR_RECOVER = 3'd4
    } wr_state_e;

    localparam logic FIFO_FULL      = 1'b0;
    localparam logic FIFO_NOT_FULL  = 1'b1;
    localparam logic RESET_ASSERTED = 1'b0;
    localparam logic STROBE_ACTIVE  = 1'b0;

    localparam int DEF_QUEUE_DEPTH    = 4;
    localparam int DEF_SETUP_TICKS    = 1;
    localparam int DEF_WR_PULSE_TICKS = 4;
    localparam int DEF_RECOVER_TICKS  = 2;
    localparam int TICK_W             = 8;

    // Counter reload value for a state lasting `ticks` clocks (counts down to 0).
    function automatic logic [TICK_W-1:0] tick_load(input int ticks);
        return (ticks > 0) ? TICK_W'(ticks - 1) : '0;
    endfunction

endpackage

// File: rtl/cmd_queue.sv
// Small synchronous FIFO: pointers wrap modulo DEPTH, level counts held entries.
module cmd_queue
    import disp_fifo_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (nrst == RESET_ASSERTED) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/disp_cmd_writer.sv
// Host-side producer for the async display command FIFO: queues command bytes
// and writes them out with a tick-timed active-low -WR strobe, gated by -FF.
module disp_cmd_writer
    import disp_fifo_defs::*;
#(
    parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
    parameter int SETUP_TICKS    = DEF_SETUP_TICKS,
    parameter int WR_PULSE_TICKS = DEF_WR_PULSE_TICKS,
    parameter int RECOVER_TICKS  = DEF_RECOVER_TICKS
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [7:0]                   cmd_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         fifo_nff,
    output logic [7:0]                   fifo_data,
    output logic                         fifo_nwr,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level,
    output logic                         busy
);

    localparam int LW = $clog2(QUEUE_DEPTH) + 1;

    logic [1:0]        nff_sync;
    logic              nff_s;
    logic              ready_en;
    logic              avail;
    logic              push;
    logic              pop;
    logic [7:0]        head;
    wr_state_e         state, state_n;
    logic [TICK_W-1:0] tick, tick_n;

    always_ff @(posedge clk or negedge nrst) begin
        if (nrst == RESET_ASSERTED) nff_sync <= {2{FIFO_FULL}};
        else                        nff_sync <= {nff_sync[0], fifo_nff};
    end
    assign nff_s = nff_sync[1];

    assign cmd_ready = ready_en && (queue_level < LW'(QUEUE_DEPTH));
    assign push      = cmd_valid && cmd_ready;

    cmd_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(8)) u_queue (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .din   (cmd_data),
        .head  (head),
        .level (queue_level)
    );

    always_comb begin
        state_n = state;
        tick_n  = tick;
        pop     = 1'b0;
        case (state)
            WR_IDLE: begin
                if (avail && nff_s == FIFO_NOT_FULL) begin
                    state_n = WR_SETUP;
                    tick_n  = tick_load(SETUP_TICKS);
                    pop     = 1'b1;
                end
            end
            WR_SETUP: begin
                if (tick == '0) begin
                    state_n = WR_PULSE;
                    tick_n  = tick_load(WR_PULSE_TICKS);
                end else begin
                    tick_n = tick - 1'b1;
                end
            end
            WR_PULSE: begin
                if (tick == '0) begin
                    state_n = WR_HOLD;
                    tick_n  = '0;
                end else begin
                    tick_n = tick - 1'b1;
                end
            end
            WR_HOLD: begin
                if (RECOVER_TICKS == 0) begin
                    state_n = WR_IDLE;
                end else begin
                    state_n = WR_RECOVER;
                    tick_n  = tick_load(RECOVER_TICKS);
                end
            end
            WR_RECOVER: begin
                if (tick == '0) state_n = WR_IDLE;
                else            tick_n  = tick - 1'b1;
            end
            default: state_n = WR_IDLE;
        endcase
    end

    // avail is the queue level seen one clock late, so a freshly pushed byte
    // reaches the FSM only on the following cycle (no bypass).
    always_ff @(posedge clk or negedge nrst) begin
        if (nrst == RESET_ASSERTED) begin
            state     <= WR_IDLE;
            tick      <= '0;
            ready_en  <= 1'b0;
            avail     <= 1'b0;
            fifo_nwr  <= ~STROBE_ACTIVE;
            fifo_data <= '0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            ready_en  <= 1'b1;
            avail     <= (queue_level != '0);
            fifo_nwr  <= (state_n == WR_PULSE) ? STROBE_ACTIVE : ~STROBE_ACTIVE;
            if (pop) fifo_data <= head;
        end
    end

    assign busy = (state != WR_IDLE);

endmodule

// File: tb/tb_disp_cmd_writer.sv
// Randomized and directed bench for disp_cmd_writer against an event-level
// model: each write is a start edge from which all strobe timing follows.
module tb_disp_cmd_writer;

    localparam int DEPTH  = 4;
    localparam int S      = 1;
    localparam int P      = 4;
    localparam int R      = 2;
    localparam int PERIOD = S + P + 1 + R + 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       fifo_nff = 1'b1;
    logic [7:0] fifo_data;
    logic       fifo_nwr;
    logic [2:0] queue_level;
    logic       busy;

    int checks = 0;
    int errors = 0;

    disp_cmd_writer #(
        .QUEUE_DEPTH(DEPTH), .SETUP_TICKS(S), .WR_PULSE_TICKS(P), .RECOVER_TICKS(R)
    ) dut (
        .clk(clk), .nrst(nrst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .fifo_nff(fifo_nff), .fifo_data(fifo_data),
        .fifo_nwr(fifo_nwr), .queue_level(queue_level), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         k;          // clock edges since reset release
    int         cur_start;  // edge at which the latest write left IDLE, -1 if none
    logic [7:0] cur_byte;
    logic [7:0] mq_data[$];
    int         mq_time[$];
    bit         nff_hist[$];
    bit         m_rdy, m_push;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            k = 0; cur_start = -1; cur_byte = 8'h00;
            mq_data.delete(); mq_time.delete(); nff_hist.delete();
        end else begin
            m_rdy  = (k >= 1) && (mq_data.size() < DEPTH);
            m_push = cmd_valid && m_rdy;
            k++;
            nff_hist.push_back(fifo_nff);
            // start needs: writer free, a byte queued two edges ago, and -FF
            // (two-flop synchronized) high.
            if ((cur_start < 0 || k >= cur_start + PERIOD) && mq_data.size() > 0 &&
                mq_time[0] <= k - 2 && k >= 3 && nff_hist[k-3]) begin
                cur_start = k;
                cur_byte  = mq_data.pop_front();
                void'(mq_time.pop_front());
            end
            if (m_push) begin
                mq_data.push_back(cmd_data);
                mq_time.push_back(k);
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_data;
        logic       e_nwr, e_busy, e_rdy;
        int         e_lvl;
        e_data = (cur_start < 0) ? 8'h00 : cur_byte;
        e_nwr  = !(cur_start >= 0 && k >= cur_start + S && k < cur_start + S + P);
        e_busy = (cur_start >= 0) && (k <= cur_start + PERIOD - 2);
        e_lvl  = mq_data.size();
        e_rdy  = (k >= 1) && (e_lvl < DEPTH);
        chk("fifo_data",   fifo_data,   e_data);
        chk("fifo_nwr",    fifo_nwr,    e_nwr);
        chk("busy",        busy,        e_busy);
        chk("queue_level", queue_level, e_lvl);
        chk("cmd_ready",   cmd_ready,   e_rdy);
    end

    // ---------------- write monitor ----------------
    logic [7:0] wr_log[$];
    logic       prev_nwr = 1'b1;
    int         max_level = 0;

    always @(negedge clk) begin
        if (prev_nwr && !fifo_nwr) wr_log.push_back(fifo_data);
        prev_nwr = fifo_nwr;
        if (int'(queue_level) > max_level) max_level = int'(queue_level);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        r = 1'b0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !r; i++) begin
            @(negedge clk) r = cmd_ready;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0;
        chk("send_accept", r, 1'b1);
    endtask

    task automatic wait_low();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) @(negedge clk) ok = !fifo_nwr;
        chk("wait_nwr_low", ok, 1'b1);
    endtask

    task automatic chk_log(input string name, input logic [7:0] first, input int n);
        chk({name, "_count"}, wr_log.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", name, i),
                (i < wr_log.size()) ? {24'h0, wr_log[i]} : 32'hFFFF, first + 8'(i));
    endtask

    // ---------------- sequence ----------------
    initial begin
        int first_low, low_cnt, busy_cnt;
        logic [7:0] d0, d1, d2;

        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;
        tick_n(4);

        // single byte, hand-computed timing relative to the accepting edge N
        send(8'hA5);
        first_low = -1; low_cnt = 0; busy_cnt = 0;
        for (int j = 0; j <= 14; j++) begin
            @(negedge clk);
            if (j == 1) d1 = fifo_data;
            if (j == 2) d2 = fifo_data;
            if (!fifo_nwr) begin
                low_cnt++;
                if (first_low < 0) first_low = j;
            end
            if (busy) busy_cnt++;
        end
        chk("t1_data_n1", d1, 8'h00);
        chk("t1_data_n2", d2, 8'hA5);
        chk("t1_first_low", first_low, 3);
        chk("t1_low_cnt", low_cnt, P);
        chk("t1_busy_cnt", busy_cnt, PERIOD - 1);
        tick_n(1);

        // back-to-back burst overflowing the queue
        wr_log.delete(); max_level = 0;
        for (int i = 1; i <= 6; i++) send(8'(i));
        tick_n(70);
        chk("t2_max_level", max_level, DEPTH);
        chk_log("t2", 8'h01, 6);

        // FIFO full while bytes arrive, then released
        wr_log.delete();
        fifo_nff = 1'b0;
        tick_n(4);
        send(8'h31); send(8'h32); send(8'h33);
        tick_n(20);
        chk("t3_level_held", queue_level, 3);
        chk("t3_no_writes", wr_log.size(), 0);
        fifo_nff = 1'b1;
        tick_n(40);
        chk_log("t3", 8'h31, 3);

        // full asserts mid-pulse: that write completes, next one waits
        wr_log.delete();
        send(8'h41); send(8'h42);
        wait_low();
        @(posedge clk); #2 fifo_nff = 1'b0;
        tick_n(25);
        chk_log("t4_held", 8'h41, 1);
        chk("t4_level", queue_level, 1);
        fifo_nff = 1'b1;
        tick_n(30);
        chk_log("t4", 8'h41, 2);

        // async reset in the middle of a pulse
        send(8'h51); send(8'h52); send(8'h53);
        wait_low();
        @(posedge clk); #3 nrst = 1'b0;
        wr_log.delete();
        #1;
        chk("t5_nwr", fifo_nwr, 1'b1);
        chk("t5_data", fifo_data, 8'h00);
        chk("t5_level", queue_level, 0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", cmd_ready, 1'b0);
        tick_n(2);
        nrst = 1'b1;
        tick_n(30);
        chk("t5_no_spurious", wr_log.size(), 0);

        // randomized traffic with occasional full
        for (int c = 0; c < 1500; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
            fifo_nff  = ($urandom_range(0, 7) != 0);
            tick_n(1);
        end
        cmd_valid = 1'b0;
        fifo_nff  = 1'b1;
        tick_n(80);
        chk("rand_drained", queue_level, 0);

        // queue full while a pop and a new valid coincide
        wr_log.delete();
        fifo_nff = 1'b0;
        tick_n(4);
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        tick_n(2);
        chk("t6_level_full", queue_level, DEPTH);
        chk("t6_ready_low", cmd_ready, 1'b0);
        fifo_nff = 1'b1;
        send(8'h65);
        send(8'h66);
        tick_n(70);
        chk_log("t6", 8'h61, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
